// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
// State encoding plus the counter-width function.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n)), never below one bit
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit combinational full adder cell.
// The only adder logic used by the serial sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one bit pair per cycle, LSB first,
// through a single full_adder cell; done pulses once per result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = clog2(WIDTH);
  localparam int RW = (WIDTH > 1) ? WIDTH - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [RW-1:0]    res_sh;
  logic [RW-1:0]    res_sh_nx;
  logic [WIDTH-1:0] res_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (carry),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // res_sh keeps only the bits already produced; the current
  // cell output completes the word on the final edge.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nx    = fa_s;
      assign res_sh_nx = res_sh;
    end else begin : g_wn
      assign res_nx    = {fa_s, res_sh};
      assign res_sh_nx = res_nx[WIDTH-1:1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          res_sh <= res_sh_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= res_nx;
            cout  <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl.
// Covers WIDTH=8 scenarios and the WIDTH=1 truth table.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int tests;
  int fails;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // observe until done; lat = edges after the accept edge
  task automatic wait_done(input bit keep, output int lat,
                           output int bcnt, output bit ovl);
    int n;
    n = 0;
    bcnt = 0;
    ovl = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!keep) start = 1'b0;
      if (busy) bcnt++;
      if (busy && done) ovl = 1'b1;
    end while (!done && n < 30);
    lat = done ? n - 1 : -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    start1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    cin1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({busy, done, sum, cout} !== 11'd0) begin
        fails++;
        $display("FAIL reset_hold%0d: busy=%b done=%b sum=%h cout=%b want 0",
                 i, busy, done, sum, cout);
      end
    end
    rst_n = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, busy1, done1, sum1, cout1} !== 6'd0) begin
      fails++;
      $display("FAIL reset_release: busy=%b done=%b busy1=%b done1=%b want 0",
               busy, done, busy1, done1);
    end
  endtask

  task automatic test_add(input logic [7:0] x, input logic [7:0] y,
                          input logic c, input logic [7:0] es,
                          input logic ec);
    int lat;
    int bcnt;
    bit ovl;
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    wait_done(1'b0, lat, bcnt, ovl);
    tests++;
    if (lat !== 8 || bcnt !== 8 || ovl) begin
      fails++;
      $display("FAIL add_timing %h+%h: lat=%0d busy=%0d ovl=%b want 8/8/0",
               x, y, lat, bcnt, ovl);
    end
    tests++;
    if (sum !== es || cout !== ec) begin
      fails++;
      $display("FAIL add_result %h+%h+%b: sum=%h cout=%b want %h %b",
               x, y, c, sum, cout, es, ec);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL add_pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_start_ignored;
    int n;
    int dcnt;
    int lat;
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    n = 0;
    dcnt = 0;
    lat = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 3) begin
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
      end
      if (done) begin
        dcnt++;
        if (lat < 0) lat = n - 1;
        tests++;
        if (sum !== 8'h30 || cout !== 1'b0) begin
          fails++;
          $display("FAIL ignore_result: sum=%h cout=%b want 30 0", sum, cout);
        end
      end
    end
    tests++;
    if (dcnt !== 1 || lat !== 8) begin
      fails++;
      $display("FAIL ignore_count: dones=%0d lat=%0d want 1 8", dcnt, lat);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int bcnt;
    bit ovl;
    int n;
    bit hold_ok;
    a = 8'h01;
    b = 8'h02;
    cin = 1'b0;
    start = 1'b1;
    wait_done(1'b1, lat, bcnt, ovl);
    tests++;
    if (lat !== 8 || sum !== 8'h03 || cout !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: lat=%0d sum=%h cout=%b want 8 03 0",
               lat, sum, cout);
    end
    a = 8'h03;
    b = 8'h04;
    n = 0;
    hold_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (!done && sum !== 8'h03) hold_ok = 1'b0;
    end while (!done && n < 30);
    tests++;
    if (!hold_ok) begin
      fails++;
      $display("FAIL b2b_hold: sum=%h want 03 during second run", sum);
    end
    tests++;
    if (n !== 9 || sum !== 8'h07 || cout !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: gap=%0d sum=%h cout=%b want 9 07 0",
               n, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    int n;
    int dcnt;
    int lat;
    int bcnt;
    bit ovl;
    a = 8'h77;
    b = 8'h11;
    cin = 1'b0;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (n < 4);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      fails++;
      $display("FAIL midop_reset: busy=%b done=%b sum=%h cout=%b want 0",
               busy, done, sum, cout);
    end
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    tests++;
    if (dcnt !== 0) begin
      fails++;
      $display("FAIL midop_nodone: active cycles=%0d want 0", dcnt);
    end
    a = 8'h5A;
    b = 8'h0F;
    cin = 1'b1;
    start = 1'b1;
    wait_done(1'b0, lat, bcnt, ovl);
    tests++;
    if (lat !== 8 || sum !== 8'h6A || cout !== 1'b0) begin
      fails++;
      $display("FAIL midop_restart: lat=%0d sum=%h cout=%b want 8 6a 0",
               lat, sum, cout);
    end
  endtask

  task automatic test_width1;
    int n;
    logic [1:0] tot;
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2);
      b1 = 1'(i >> 1);
      cin1 = 1'(i);
      tot = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        start1 = 1'b0;
        if (n == 1) begin
          tests++;
          if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            fails++;
            $display("FAIL w1_busy%0d: busy=%b done=%b want 1 0",
                     i, busy1, done1);
          end
        end
      end while (!done1 && n < 6);
      tests++;
      if (n !== 2 || sum1 !== tot[0] || cout1 !== tot[1]) begin
        fails++;
        $display("FAIL w1_add%0d: lat=%0d sum=%b cout=%b want 1 %b %b",
                 i, n - 1, sum1, cout1, tot[0], tot[1]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0);
    test_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    test_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
